// File: rtl/twofish_qperm_pipe_if.sv
// Handshake bundle for the Twofish q-permutation pipeline: input word stream,
// output word stream and the accepted-word counter.
interface twofish_qperm_pipe_if #(
    parameter int unsigned LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic [LANES-1:0]     in_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [15:0]          out_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/twofish_qperm_pipe.sv
// Two-stage pipelined Twofish q0/q1 byte permutation, one select bit per lane.
// Define QPERM_COUNT_EN to enable the 16-bit accepted-word counter on out_cnt.
module twofish_qperm_pipe #(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    twofish_qperm_pipe_if.slave  bus
);
    localparam int unsigned W = 8 * LANES;

    // Indexed [q1][table t0..t3][nibble].
    localparam logic [3:0] TBL [2][4][16] = '{
        '{
            '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2, 4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4},
            '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5, 4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD},
            '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0, 4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1},
            '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA}
        },
        '{
            '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE, 4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5},
            '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7, 4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8},
            '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA, 4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF},
            '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE, 4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA}
        }
    };

    function automatic logic [3:0] ror1(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

    // One mix-and-lookup round; k selects the table pair (t0/t1 or t2/t3).
    function automatic logic [7:0] q_round(input logic sel, input logic [1:0] k,
                                           input logic [3:0] a, input logic [3:0] b);
        logic [3:0] a_mix;
        logic [3:0] b_mix;
        a_mix = a ^ b;
        b_mix = a ^ ror1(b) ^ {a[0], 3'b000};
        return {TBL[sel][k][a_mix], TBL[sel][k + 2'd1][b_mix]};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_ab_q, s1_ab_d;
    logic [LANES-1:0] s1_sel_q, s1_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             s1_load;
    logic             s2_load;
    logic [7:0]       r2;

    always_comb begin
        s2_load     = !out_valid_q || bus.out_ready;
        s1_load     = !s1_valid_q || s2_load;
        s1_valid_d  = s1_load ? bus.in_valid : s1_valid_q;
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        s1_ab_d     = s1_ab_q;
        s1_sel_d    = s1_sel_q;
        out_data_d  = out_data_q;
        r2          = '0;
        if (s1_load && bus.in_valid) begin
            s1_sel_d = bus.in_sel;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_ab_d[8*i +: 8] = q_round(bus.in_sel[i], 2'd0,
                                            bus.in_data[8*i+4 +: 4], bus.in_data[8*i +: 4]);
            end
        end
        if (s2_load && s1_valid_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r2 = q_round(s1_sel_q[i], 2'd2, s1_ab_q[8*i+4 +: 4], s1_ab_q[8*i +: 4]);
                // Round result is {a4,b4}; the output byte puts b4 on top.
                out_data_d[8*i +: 8] = {r2[3:0], r2[7:4]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ab_q     <= '0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ab_q     <= s1_ab_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef QPERM_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.in_valid && s1_load) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_cnt = cnt_q;
`else
    assign bus.out_cnt = '0;
`endif
endmodule

// File: tb/tb_twofish_qperm_pipe.sv
// Randomized scoreboard bench for twofish_qperm_pipe (LANES=4) against a
// per-byte q0/q1 reference and an occupancy/latency model of the pipeline.
module tb_twofish_qperm_pipe;
    logic clk;
    logic rst;

    twofish_qperm_pipe_if #(.LANES(4)) bus ();

    twofish_qperm_pipe #(.LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned tq [2][4][16] = '{
        '{
            '{'h8, 'h1, 'h7, 'hD, 'h6, 'hF, 'h3, 'h2, 'h0, 'hB, 'h5, 'h9, 'hE, 'hC, 'hA, 'h4},
            '{'hE, 'hC, 'hB, 'h8, 'h1, 'h2, 'h3, 'h5, 'hF, 'h4, 'hA, 'h6, 'h7, 'h0, 'h9, 'hD},
            '{'hB, 'hA, 'h5, 'hE, 'h6, 'hD, 'h9, 'h0, 'hC, 'h8, 'hF, 'h3, 'h2, 'h4, 'h7, 'h1},
            '{'hD, 'h7, 'hF, 'h4, 'h1, 'h2, 'h6, 'hE, 'h9, 'hB, 'h3, 'h0, 'h8, 'h5, 'hC, 'hA}
        },
        '{
            '{'h2, 'h8, 'hB, 'hD, 'hF, 'h7, 'h6, 'hE, 'h3, 'h1, 'h9, 'h4, 'h0, 'hA, 'hC, 'h5},
            '{'h1, 'hE, 'h2, 'hB, 'h4, 'hC, 'h3, 'h7, 'h6, 'hD, 'hA, 'h5, 'hF, 'h9, 'h0, 'h8},
            '{'h4, 'hC, 'h7, 'h5, 'h1, 'h6, 'h9, 'hA, 'h0, 'hE, 'hD, 'h8, 'h2, 'hB, 'h3, 'hF},
            '{'hB, 'h9, 'h5, 'h1, 'hC, 'h3, 'hD, 'hE, 'h6, 'h4, 'h7, 'hF, 'h2, 'h0, 'h8, 'hA}
        }
    };

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] qref(input bit s, input logic [7:0] x);
        int unsigned a, b, am, bm;
        a = x[7:4];
        b = x[3:0];
        for (int r = 0; r < 2; r++) begin
            am = a ^ b;
            bm = (a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((a & 1) << 3)) & 15;
            a  = tq[s][2*r][am];
            b  = tq[s][2*r+1][bm];
        end
        return 8'(b * 16 + a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] y;
        for (int i = 0; i < 4; i++) y[8*i +: 8] = qref(s[i], d[8*i +: 8]);
        return y;
    endfunction

    typedef struct {
        logic [31:0]     data;
        longint unsigned e;
    } item_t;

    item_t           sb[$];
    longint unsigned ecount = 0;
    int unsigned     acc_model = 0;
    bit              stall_prev = 0;
    logic [31:0]     held;

    always @(posedge clk) ecount <= ecount + 1;

    // Scoreboard: a word is visible from the second edge after its accept.
    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            sb.delete();
            acc_model  = 0;
            stall_prev = 0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2 || bus.out_ready));
            check("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0 && ecount > sb[0].e));
`ifdef QPERM_COUNT_EN
            check("out_cnt", 64'(bus.out_cnt), 64'(acc_model[15:0]));
`else
            check("out_cnt", 64'(bus.out_cnt), 64'd0);
`endif
            if (stall_prev) check("hold_data", 64'(bus.out_data), 64'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    it = sb.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(it.data));
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{ref_word(bus.in_data, bus.in_sel), ecount + 1});
                acc_model++;
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] s);
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("push_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] d, input logic [3:0] s,
                            input logic [31:0] exp);
        drain();
        push_word(d, s);
        @(negedge clk);
        check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.out_data), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic run(input int n, input int vpct, input int rpct, input bit sweep);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        logic [31:0] d;
        while (sent < n) begin
            if (!bus.in_valid && $urandom_range(99) < vpct) begin
                if (sweep) begin
                    for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'((sent + 64 * i) & 255);
                end else begin
                    d = $urandom;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.in_sel   = 4'($urandom);
            end
            bus.out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            cyc++;
            if (cyc > n * 40 + 100) begin
                check("run_timeout", 64'(sent), 64'(n));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int nacc;
        bit acc;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        directed("t1", 32'h0000_0000, 4'b0000, 32'hA9A9_A9A9);
        // Lanes: q1(01)=F3, q0(01)=67, q1(00)=75, q0(00)=A9.
        directed("t2", 32'h0000_0101, 4'b0101, 32'hA975_67F3);

        run(256, 80, 60, 1'b1);
        drain();
        run(400, 70, 50, 1'b0);
        drain();

        // Output stalled for 5 cycles while the source keeps offering words.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        bus.in_sel    = 4'($urandom);
        nacc = 0;
        repeat (5) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                bus.in_data = $urandom;
                bus.in_sel  = 4'($urandom);
            end
        end
        check("t4_accepts", 64'(nacc), 64'd2);
        check("t4_in_ready", 64'(bus.in_ready), 64'd0);
        run(20, 100, 100, 1'b0);
        drain();

        // Reset with two words in flight.
        bus.out_ready = 1'b0;
        push_word($urandom, 4'($urandom));
        push_word($urandom, 4'($urandom));
        do_reset();
        @(negedge clk);
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_out_cnt", 64'(bus.out_cnt), 64'd0);
        @(posedge clk); #1;
        directed("t5_post", 32'h0000_0101, 4'b0101, 32'hA975_67F3);

`ifdef QPERM_COUNT_EN
        do_reset();
        run(65537, 100, 100, 1'b0);
        drain();
        check("t6_cnt_wrap", 64'(bus.out_cnt), 64'd1);
`else
        check("t6_cnt_tied", 64'(bus.out_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
